mac_stream_producer: RTL and testbench
======================================

# mac_stream_producer

Upstream producer for the output FIFO. It accepts a stream of signed operand pairs on an AXI-Stream-style slave port and computes one dot product per VECLEN pairs in a 3-stage multiply-accumulate pipeline. It then writes the saturated result into the FIFO with a one-cycle `wr_en` pulse. Results are never dropped: a slot is reserved against the FIFO's `capacity` before a vector is admitted.

## Interface
- `INW`, 14: width of each signed operand.
- `OUTW`, 28: result width; must equal the FIFO data width.
- `DEPTH`, 8: FIFO depth; sizes `capacity` and the in-flight counter.
- `VECLEN`, 4: operand pairs per result (≥1).
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `INPUT_TDATA`  in  2*INW: `{a[INW-1:0], b[INW-1:0]}`; a is the high half; both are signed.
- `INPUT_TVALID`  in  1: operand pair valid.
- `INPUT_TREADY`  out  1: pair accepted on an edge where TVALID and TREADY are both 1.
- `capacity`  in  $clog2(DEPTH+1): free FIFO slots, from the FIFO.
- `data_out`  out  OUTW: result to FIFO `data_in`.
- `wr_en`  out  1: one-cycle write strobe to the FIFO.
- `sat_flag`  out  1: high together with `wr_en` when the result was clipped.

## Operation
- **Control FSM**
  - States: `WAIT0` → `WAIT1` → `RUN`.
  - Reset forces `WAIT0`; each wait state lasts exactly one cycle; `RUN` is held until reset.
  - The two wait cycles cover the FIFO's post-reset initialisation of `capacity`.
- **Reset values:** `INPUT_TREADY=0`, `wr_en=0`, `sat_flag=0`, `data_out=0`, accumulator 0, element counter 0, in-flight counter 0, all pipeline valid bits 0.
- **Element counter**
  - Range 0..VECLEN-1; increments on each handshake and wraps from VECLEN-1 to 0.
  - An element with count 0 is "first"; count VECLEN-1 is "last"; both when VECLEN=1.
- **In-flight counter**, width $clog2(DEPTH+1):
  - +1 on the handshake of a first element.
  - −1 on every cycle with `wr_en=1`.
  - Both in the same cycle → unchanged.
- **Ready rule:** `INPUT_TREADY = (state==RUN) && (elem_cnt!=0 || capacity > inflight)`.
  - It is combinational only from registers and `capacity`; there is no path from `INPUT_TVALID`.
  - Elements after the first are always accepted, because the slot is already reserved.
- **Pipeline**, stage valid bits advance unconditionally with no stall:
  - Stage 1 registers a, b and the last-flag.
  - Stage 2 registers the full-precision signed product (2*INW bits).
  - Stage 3 forms `sum = acc + sign-extended product` in ACCW = 2*INW + $clog2(VECLEN) + 1 bits.
- **Stage 3 on a non-last element:** `acc <= sum`; `wr_en <= 0`.
- **Stage 3 on a last element:**
  - `acc <= 0`; `wr_en <= 1`; `data_out <= sat(sum)`.
  - `sat_flag <= 1` iff clipped.
  - `sat` clamps to [−2^(OUTW−1), 2^(OUTW−1)−1].
- `data_out` holds its last value when `wr_en=0`.
- **Boundaries**
  - `capacity=0` with `inflight=0`: first elements are blocked; a partial vector still completes.
  - `capacity` rising due to downstream reads takes effect the same cycle.
  - `inflight` never exceeds DEPTH.
  - `wr_en` is never asserted while the FIFO is full.
  - Reset mid-vector discards the partial sum and every in-flight stage; no `wr_en` results from elements accepted before reset.

## Timing
- Handshake in cycle H → `wr_en`/`data_out` valid in cycle H+3 for the last element of a vector. The FIFO samples them at the end of H+3.
- Throughput: one pair per cycle; back-to-back vectors produce one result every VECLEN cycles with no bubble.
- `wr_en` is always a single-cycle pulse per vector. Two consecutive cycles of `wr_en` occur only when VECLEN=1.
- After reset deasserts: `INPUT_TREADY=0` for exactly 2 cycles, then follows the ready rule.

## Test plan
1. **Reset release** (reset held 2 cycles, FIFO attached, TVALID=1):
   - TREADY=0 for the 2 cycles after release, then 1 with `capacity=8`.
   - `wr_en=0` and `data_out=0` throughout.
2. **One vector** (a={1,2,3,4}, b={5,6,7,8}, back-to-back):
   - Exactly one `wr_en` pulse, 3 cycles after the 4th handshake.
   - `data_out=70`, `sat_flag=0`; the FIFO later presents 70 on `AXIS_TDATA`.
3. **Saturation**:
   - Four pairs a=b=−8192 → `data_out=134217727`, `sat_flag=1`.
   - Four pairs a=−8192, b=8191 → `data_out=−134217728` (0x8000000), `sat_flag=1`.
4. **Backpressure** (downstream AXIS_TREADY=0, 10 vectors offered continuously):
   - Exactly 8 `wr_en` pulses occur; TREADY drops at the first element of vector 9 and stays 0.
   - Raising AXIS_TREADY for one read re-opens TREADY; vector 9 completes with its correct value.
5. **Credit edge** (capacity driven to 1, inflight 0):
   - A vector is admitted; TREADY stays 1 for its remaining 3 elements.
   - TREADY is 0 at the next first element until `wr_en` has fired and `capacity` has risen again.
6. **Reset mid-vector** (2 elements of {100,100} accepted, reset for 1 cycle, then vector a={1,1,1,1}, b={1,1,1,1}):
   - No `wr_en` from the aborted vector.
   - The next result is `data_out=4`.

Source files
------------

// File: rtl/mac_stream_producer_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mac_stream_producer_if
// Bundles the operand stream and the FIFO write side of mac_stream_producer.
//
// Handshake: a pair moves on a rising clk edge where INPUT_TVALID and
// INPUT_TREADY are both 1. TREADY never depends on TVALID. Once a pair is
// offered, TVALID and TDATA are held until that edge.
//
//   INPUT_TDATA   {a, b}, a in the high half, both signed
//   INPUT_TVALID  operand pair valid
//   INPUT_TREADY  producer can take a pair this cycle
//   capacity      free slots reported by the FIFO
//   data_out      saturated dot product, valid while wr_en=1
//   wr_en         single-cycle FIFO write strobe
//   sat_flag      result was clipped, high only together with wr_en
//
// slave  : the producer's view
// master : the environment's view (operand source + FIFO)
// ---------------------------------------------------------------------------
interface mac_stream_producer_if #(
    parameter int INW   = 14,
    parameter int OUTW  = 28,
    parameter int DEPTH = 8
);
    localparam int CAPW = $clog2(DEPTH + 1);

    logic [2*INW-1:0] INPUT_TDATA;
    logic             INPUT_TVALID;
    logic             INPUT_TREADY;
    logic [CAPW-1:0]  capacity;
    logic [OUTW-1:0]  data_out;
    logic             wr_en;
    logic             sat_flag;

    modport slave (
        input  INPUT_TDATA,
        input  INPUT_TVALID,
        input  capacity,
        output INPUT_TREADY,
        output data_out,
        output wr_en,
        output sat_flag
    );

    modport master (
        output INPUT_TDATA,
        output INPUT_TVALID,
        output capacity,
        input  INPUT_TREADY,
        input  data_out,
        input  wr_en,
        input  sat_flag
    );
endinterface

// File: rtl/mac_stream_producer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mac_stream_producer
// Takes signed operand pairs and produces one saturated dot product per
// VECLEN pairs through a 3-stage multiply-accumulate pipeline, writing
// each result into a downstream FIFO with a one-cycle wr_en pulse.
// A FIFO slot is reserved when the first element of a vector is accepted,
// so a result can never meet a full FIFO and nothing is ever dropped.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        mac_stream_producer_if.slave (operand stream + FIFO write)
//   dbg_state  current control FSM state (0=WAIT0, 1=WAIT1, 2=RUN)
//
// Latency: handshake of the last element in cycle H -> wr_en in H+3.
// Assumes ACCW >= OUTW (true for the default parameters).
// ---------------------------------------------------------------------------
module mac_stream_producer #(
    parameter int INW    = 14,
    parameter int OUTW   = 28,
    parameter int DEPTH  = 8,
    parameter int VECLEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mac_stream_producer_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int CAPW  = $clog2(DEPTH + 1);
    localparam int CNTW  = (VECLEN > 1) ? $clog2(VECLEN) : 1;
    localparam int PRODW = 2 * INW;
    localparam int ACCW  = 2 * INW + $clog2(VECLEN) + 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(VECLEN - 1);

    typedef enum logic [1:0] {
        ST_WAIT0 = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic in_ready;
    logic hs;
    logic elem_first;
    logic elem_last;

    logic [CNTW-1:0] elem_cnt_q, elem_cnt_d;
    logic [CAPW-1:0] inflight_q, inflight_d;

    // Stage 1: operands
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_last_q, s1_last_d;
    logic signed [INW-1:0]  s1_a_q, s1_a_d;
    logic signed [INW-1:0]  s1_b_q, s1_b_d;

    // Stage 2: full-precision product
    logic                   s2_valid_q, s2_valid_d;
    logic                   s2_last_q, s2_last_d;
    logic signed [PRODW-1:0] s2_prod_q, s2_prod_d;

    // Stage 3: accumulator and FIFO write
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] sum;
    logic                   fits;
    logic [OUTW-1:0]        sat_val;
    logic [OUTW-1:0]        data_out_q, data_out_d;
    logic                   wr_en_q, wr_en_d;
    logic                   sat_flag_q, sat_flag_d;

    // ---------------- control FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT0;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- control FSM: next state ----------------
    // The two wait cycles give the FIFO time to publish a valid capacity.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT0: state_d = ST_WAIT1;
            ST_WAIT1: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_WAIT0;
        endcase
    end

    // ---------------- control FSM: outputs ----------------
    // Non-first elements already own a slot, so only the first element of
    // a vector checks the FIFO credit. No path from TVALID.
    always_comb begin
        in_ready = 1'b0;
        if (state_q == ST_RUN) begin
            in_ready = (elem_cnt_q != '0) || (bus.capacity > inflight_q);
        end
    end

    // ---------------- element counter and slot reservation ----------------
    always_comb begin
        hs         = bus.INPUT_TVALID && in_ready;
        elem_first = (elem_cnt_q == '0);
        elem_last  = (elem_cnt_q == LAST_IDX);

        elem_cnt_d = elem_cnt_q;
        if (hs) begin
            elem_cnt_d = elem_last ? '0 : elem_cnt_q + CNTW'(1);
        end

        // A reservation and a write in the same cycle cancel out.
        inflight_d = inflight_q;
        case ({hs && elem_first, wr_en_q})
            2'b10:   inflight_d = inflight_q + CAPW'(1);
            2'b01:   inflight_d = inflight_q - CAPW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // ---------------- pipeline datapath ----------------
    always_comb begin
        // Stage 1: operand registers only load on a handshake.
        s1_valid_d = hs;
        s1_last_d  = hs ? elem_last : s1_last_q;
        s1_a_d     = hs ? $signed(bus.INPUT_TDATA[2*INW-1:INW]) : s1_a_q;
        s1_b_d     = hs ? $signed(bus.INPUT_TDATA[INW-1:0])     : s1_b_q;

        // Stage 2
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_prod_d  = PRODW'(s1_a_q) * PRODW'(s1_b_q);

        // Stage 3
        sum = acc_q + $signed({{(ACCW-PRODW){s2_prod_q[PRODW-1]}}, s2_prod_q});

        // The sum fits OUTW bits when everything above the OUTW sign bit
        // is a copy of it.
        fits = (&sum[ACCW-1:OUTW-1]) || (~|sum[ACCW-1:OUTW-1]);
        if (fits) begin
            sat_val = sum[OUTW-1:0];
        end else if (sum[ACCW-1]) begin
            sat_val = {1'b1, {(OUTW-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(OUTW-1){1'b1}}};
        end

        acc_d      = acc_q;
        wr_en_d    = 1'b0;
        sat_flag_d = 1'b0;
        data_out_d = data_out_q;
        if (s2_valid_q) begin
            if (s2_last_q) begin
                acc_d      = '0;
                wr_en_d    = 1'b1;
                data_out_d = sat_val;
                sat_flag_d = ~fits;
            end else begin
                acc_d = sum;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            elem_cnt_q <= '0;
            inflight_q <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            wr_en_q    <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            elem_cnt_q <= elem_cnt_d;
            inflight_q <= inflight_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_prod_q  <= s2_prod_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            wr_en_q    <= wr_en_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.INPUT_TREADY = in_ready;
    assign bus.data_out     = data_out_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.sat_flag     = sat_flag_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_mac_stream_producer.sv
`timescale 1ns/1ps
// Directed bench for mac_stream_producer with a small FIFO model attached.
module tb_mac_stream_producer;
    localparam int INW    = 14;
    localparam int OUTW   = 28;
    localparam int DEPTH  = 8;
    localparam int VECLEN = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_stream_producer_if #(.INW(INW), .OUTW(OUTW), .DEPTH(DEPTH)) bus ();

    mac_stream_producer #(
        .INW(INW), .OUTW(OUTW), .DEPTH(DEPTH), .VECLEN(VECLEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- FIFO model ----------------
    logic [OUTW-1:0] fifo_mem [0:DEPTH-1];
    logic [2:0]      wp = '0;
    logic [2:0]      rp = '0;
    logic [3:0]      fcnt = '0;
    logic            rd_en;
    logic            rd_fire;
    logic [3:0]      cap_base;
    logic [OUTW-1:0] fifo_head;

    assign rd_fire   = rd_en && (fcnt != 4'd0);
    assign fifo_head = fifo_mem[rp];

    always_comb begin
        bus.capacity = (cap_base >= fcnt) ? cap_base - fcnt : 4'd0;
    end

    always @(posedge clk) begin
        if (reset) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (bus.wr_en) begin
                fifo_mem[wp] <= bus.data_out;
                wp <= wp + 3'd1;
            end
            if (rd_fire) rp <= rp + 3'd1;
            fcnt <= fcnt + (bus.wr_en ? 4'd1 : 4'd0) - (rd_fire ? 4'd1 : 4'd0);
        end
    end

    // ---------------- scoreboard ----------------
    logic [OUTW-1:0] exp_q[$];
    logic            exp_sat_q[$];
    logic [OUTW-1:0] got_d[$];
    logic            got_s[$];
    int              got_c[$];
    int              full_wr_err = 0;
    int              next_res = 0;
    int              n_vec = 0;
    int              n_miss = 0;

    always @(negedge clk) begin
        if (!reset && bus.wr_en === 1'b1) begin
            got_d.push_back(bus.data_out);
            got_s.push_back(bus.sat_flag);
            got_c.push_back(cyc);
            if (fcnt >= 4'd8) full_wr_err = full_wr_err + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair and returns after the edge that accepts it.
    task automatic send_pair(input int a, input int b, output int hs_cyc);
        int budget;
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        budget = 0;
        bus.INPUT_TDATA  = {av[INW-1:0], bv[INW-1:0]};
        bus.INPUT_TVALID = 1'b1;
        while (bus.INPUT_TREADY !== 1'b1 && budget < 60) begin
            tick();
            budget++;
        end
        if (budget >= 60) begin
            n_vec++;
            n_miss++;
            $display("FAIL handshake_timeout: a=%0d b=%0d ready=%b", a, b, bus.INPUT_TREADY);
        end
        hs_cyc = cyc;
        tick();
    endtask

    task automatic wait_results(input int target);
        int budget;
        budget = 0;
        while (got_d.size() < target && budget < 100) begin
            tick();
            budget++;
        end
        if (got_d.size() < target) begin
            n_vec++;
            n_miss++;
            $display("FAIL result_timeout: got %0d results, need %0d", got_d.size(), target);
        end
    endtask

    task automatic drain_fifo();
        int budget;
        budget = 0;
        rd_en = 1'b1;
        while (fcnt != 4'd0 && budget < 20) begin
            tick();
            budget++;
        end
        rd_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [1:0] exp_st [3];
        exp_st = '{2'd0, 2'd1, 2'd2};
        reset = 1'b1;
        bus.INPUT_TVALID = 1'b1;
        bus.INPUT_TDATA  = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (bus.INPUT_TREADY !== 1'b0 || bus.wr_en !== 1'b0 || bus.data_out !== '0) begin
                n_miss++;
                $display("FAIL reset_hold: ready=%b wr_en=%b data=%0d, need 0/0/0",
                         bus.INPUT_TREADY, bus.wr_en, bus.data_out);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (dbg_state !== exp_st[i]) begin
                n_miss++;
                $display("FAIL reset_state[%0d]: got %0d need %0d", i, dbg_state, exp_st[i]);
            end
            n_vec++;
            if (bus.INPUT_TREADY !== (i == 2)) begin
                n_miss++;
                $display("FAIL reset_ready[%0d]: got %b need %b", i, bus.INPUT_TREADY, (i == 2));
            end
            n_vec++;
            if (bus.wr_en !== 1'b0 || bus.data_out !== '0) begin
                n_miss++;
                $display("FAIL reset_outputs[%0d]: wr_en=%b data=%0d need 0/0",
                         i, bus.wr_en, bus.data_out);
            end
            if (i == 2) bus.INPUT_TVALID = 1'b0;
            else tick();
        end
    endtask

    task automatic test_one_vector();
        int a [4];
        int b [4];
        int hs;
        int base;
        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        base = got_d.size();
        for (int i = 0; i < 4; i++) send_pair(a[i], b[i], hs);
        bus.INPUT_TVALID = 1'b0;
        wait_results(base + 1);
        tick();
        tick();
        n_vec++;
        if (got_d.size() !== base + 1) begin
            n_miss++;
            $display("FAIL one_vec_pulses: got %0d need 1", got_d.size() - base);
        end
        n_vec++;
        if (got_d[base] !== 28'd70) begin
            n_miss++;
            $display("FAIL one_vec_data: got %0d need 70", got_d[base]);
        end
        n_vec++;
        if (got_s[base] !== 1'b0) begin
            n_miss++;
            $display("FAIL one_vec_sat: got %b need 0", got_s[base]);
        end
        n_vec++;
        if (got_c[base] !== hs + 3) begin
            n_miss++;
            $display("FAIL one_vec_latency: wr_en at %0d need %0d", got_c[base], hs + 3);
        end
        n_vec++;
        if (fcnt !== 4'd1 || fifo_head !== 28'd70) begin
            n_miss++;
            $display("FAIL one_vec_fifo: count=%0d head=%0d need 1/70", fcnt, fifo_head);
        end
        next_res = base + 1;
        drain_fifo();
    endtask

    task automatic test_saturation();
        int hs;
        int base;
        base = got_d.size();
        exp_q.push_back(28'h7FFFFFF);
        exp_sat_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) send_pair(-8192, -8192, hs);
        exp_q.push_back(28'h8000000);
        exp_sat_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) send_pair(-8192, 8191, hs);
        bus.INPUT_TVALID = 1'b0;
        wait_results(base + 2);
        for (int i = 0; i < 2; i++) begin
            logic [OUTW-1:0] e;
            logic es;
            e  = exp_q.pop_front();
            es = exp_sat_q.pop_front();
            n_vec++;
            if (got_d[next_res] !== e) begin
                n_miss++;
                $display("FAIL sat_data[%0d]: got 0x%07h need 0x%07h", i, got_d[next_res], e);
            end
            n_vec++;
            if (got_s[next_res] !== es) begin
                n_miss++;
                $display("FAIL sat_flag[%0d]: got %b need %b", i, got_s[next_res], es);
            end
            next_res++;
        end
        drain_fifo();
    endtask

    task automatic test_back_to_back();
        int a [8];
        int b [8];
        int hs [8];
        int base;
        a = '{1, 2, 3, 4, -3, 7, 0, -1};
        b = '{1, 1, 1, 1, 2, -5, 9, -4};
        base = got_d.size();
        exp_q.push_back(28'd10);
        exp_q.push_back(-28'sd37);
        for (int i = 0; i < 8; i++) send_pair(a[i], b[i], hs[i]);
        bus.INPUT_TVALID = 1'b0;
        wait_results(base + 2);
        for (int i = 0; i < 2; i++) begin
            logic [OUTW-1:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (got_d[next_res] !== e) begin
                n_miss++;
                $display("FAIL b2b_data[%0d]: got %0d need %0d", i, $signed(got_d[next_res]), $signed(e));
            end
            n_vec++;
            if (got_c[next_res] !== hs[4*i+3] + 3) begin
                n_miss++;
                $display("FAIL b2b_latency[%0d]: wr_en at %0d need %0d", i, got_c[next_res], hs[4*i+3] + 3);
            end
            next_res++;
        end
        n_vec++;
        if (got_c[base + 1] - got_c[base] !== VECLEN) begin
            n_miss++;
            $display("FAIL b2b_spacing: got %0d need %0d", got_c[base + 1] - got_c[base], VECLEN);
        end
        drain_fifo();
    endtask

    task automatic test_backpressure();
        int hs;
        int base;
        base = got_d.size();
        rd_en = 1'b0;
        for (int v = 1; v <= 8; v++) begin
            exp_q.push_back(OUTW'(4 * v));
            for (int e = 0; e < 4; e++) send_pair(v, 1, hs);
        end
        bus.INPUT_TDATA = {14'd9, 14'd1};
        wait_results(base + 8);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (bus.INPUT_TREADY !== 1'b0) begin
                n_miss++;
                $display("FAIL bp_blocked[%0d]: ready got %b need 0", k, bus.INPUT_TREADY);
            end
            tick();
        end
        n_vec++;
        if (got_d.size() !== base + 8) begin
            n_miss++;
            $display("FAIL bp_pulse_count: got %0d need 8", got_d.size() - base);
        end
        n_vec++;
        if (fcnt !== 4'd8 || fifo_head !== 28'd4) begin
            n_miss++;
            $display("FAIL bp_fifo_full: count=%0d head=%0d need 8/4", fcnt, fifo_head);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_vec++;
        if (bus.INPUT_TREADY !== 1'b1) begin
            n_miss++;
            $display("FAIL bp_reopen: ready got %b need 1", bus.INPUT_TREADY);
        end
        exp_q.push_back(28'd36);
        for (int e = 0; e < 4; e++) send_pair(9, 1, hs);
        bus.INPUT_TDATA = {14'd10, 14'd1};
        wait_results(base + 9);
        tick();
        tick();
        n_vec++;
        if (bus.INPUT_TREADY !== 1'b0) begin
            n_miss++;
            $display("FAIL bp_full_again: ready got %b need 0", bus.INPUT_TREADY);
        end
        bus.INPUT_TVALID = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic [OUTW-1:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (got_d[next_res] !== e) begin
                n_miss++;
                $display("FAIL bp_data[%0d]: got %0d need %0d", i, got_d[next_res], e);
            end
            next_res++;
        end
        rd_en = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            n_vec++;
            if (fifo_head !== OUTW'(4 * k)) begin
                n_miss++;
                $display("FAIL bp_fifo_order[%0d]: got %0d need %0d", k, fifo_head, 4 * k);
            end
            tick();
        end
        rd_en = 1'b0;
        n_vec++;
        if (full_wr_err !== 0) begin
            n_miss++;
            $display("FAIL bp_write_when_full: got %0d writes need 0", full_wr_err);
        end
    endtask

    task automatic test_credit_edge();
        int hs;
        int budget;
        int base;
        base = got_d.size();
        cap_base = 4'd1;
        exp_q.push_back(28'd24);
        exp_q.push_back(28'd0);
        send_pair(2, 3, hs);
        for (int e = 1; e < 4; e++) begin
            n_vec++;
            if (bus.INPUT_TREADY !== 1'b1) begin
                n_miss++;
                $display("FAIL credit_rest[%0d]: ready got %b need 1", e, bus.INPUT_TREADY);
            end
            send_pair(2, 3, hs);
        end
        bus.INPUT_TDATA  = {14'd1, 14'd5};
        bus.INPUT_TVALID = 1'b1;
        budget = 0;
        while (bus.wr_en !== 1'b1 && budget < 20) begin
            n_vec++;
            if (bus.INPUT_TREADY !== 1'b0) begin
                n_miss++;
                $display("FAIL credit_block_pre: ready got %b need 0", bus.INPUT_TREADY);
            end
            tick();
            budget++;
        end
        n_vec++;
        if (bus.wr_en !== 1'b1 || bus.INPUT_TREADY !== 1'b0) begin
            n_miss++;
            $display("FAIL credit_at_write: wr_en=%b ready=%b need 1/0", bus.wr_en, bus.INPUT_TREADY);
        end
        tick();
        n_vec++;
        if (bus.INPUT_TREADY !== 1'b0 || bus.capacity !== 4'd0) begin
            n_miss++;
            $display("FAIL credit_after_write: ready=%b cap=%0d need 0/0", bus.INPUT_TREADY, bus.capacity);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_vec++;
        if (bus.INPUT_TREADY !== 1'b1) begin
            n_miss++;
            $display("FAIL credit_reopen: ready got %b need 1", bus.INPUT_TREADY);
        end
        send_pair(1, 5, hs);
        send_pair(-1, 5, hs);
        send_pair(1, 5, hs);
        send_pair(-1, 5, hs);
        bus.INPUT_TVALID = 1'b0;
        wait_results(base + 2);
        for (int i = 0; i < 2; i++) begin
            logic [OUTW-1:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (got_d[next_res] !== e) begin
                n_miss++;
                $display("FAIL credit_data[%0d]: got %0d need %0d", i, got_d[next_res], e);
            end
            next_res++;
        end
        drain_fifo();
        cap_base = 4'd8;
    endtask

    task automatic test_reset_mid_vector();
        int hs;
        int base;
        send_pair(100, 100, hs);
        send_pair(100, 100, hs);
        bus.INPUT_TVALID = 1'b0;
        reset = 1'b1;
        base = got_d.size();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_vec++;
        if (got_d.size() !== base) begin
            n_miss++;
            $display("FAIL mid_reset_no_write: got %0d pulses need 0", got_d.size() - base);
        end
        for (int e = 0; e < 4; e++) send_pair(1, 1, hs);
        bus.INPUT_TVALID = 1'b0;
        wait_results(base + 1);
        tick();
        tick();
        n_vec++;
        if (got_d.size() !== base + 1) begin
            n_miss++;
            $display("FAIL mid_reset_pulses: got %0d need 1", got_d.size() - base);
        end
        n_vec++;
        if (got_d[base] !== 28'd4 || got_s[base] !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_reset_data: got %0d sat=%b need 4 sat=0", got_d[base], got_s[base]);
        end
        next_res = base + 1;
        drain_fifo();
    endtask

    initial begin
        reset            = 1'b1;
        bus.INPUT_TVALID = 1'b0;
        bus.INPUT_TDATA  = '0;
        rd_en            = 1'b0;
        cap_base         = 4'd8;

        test_reset();
        test_one_vector();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_credit_edge();
        test_reset_mid_vector();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
